// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and default datapath sizes.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the shared {acc, q} datapath: a right-shifting shift-add
// step for multiply or a left-shifting restoring shift-subtract step for divide.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] cur,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted_hi;
  logic             ge;
  logic [WIDTH-1:0] trial;

  assign acc = cur[2*WIDTH-1:WIDTH];
  assign q   = cur[WIDTH-1:0];

  // Compute the next {acc, q} for whichever operation is active.
  always_comb begin
    sum        = {1'b0, acc};
    shifted_hi = {acc, q[WIDTH-1]};
    ge         = 1'b0;
    trial      = {WIDTH{1'b0}};
    nxt        = cur;
    if (is_div) begin
      // acc stays below the divisor, so the shifted partial remainder fits in WIDTH+1 bits
      ge    = (shifted_hi >= {1'b0, m});
      trial = shifted_hi[WIDTH-1:0] - m;
      if (ge) begin
        nxt = {trial, q[WIDTH-2:0], 1'b1};
      end else begin
        nxt = {shifted_hi[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (q[0]) begin
        sum = {1'b0, acc} + {1'b0, m};
      end else begin
        sum = {1'b0, acc};
      end
      nxt = {sum, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers,
// handling signed operands by magnitude iteration plus a final sign fix-up.
module mult_div_unit #(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int ITER  = mdu_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               dbz;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] acc_q;

  logic [2*WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   hi_n;
  logic [WIDTH-1:0]   lo_n;
  logic [2*WIDTH-1:0] prod_n;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .cur    (acc_q),
    .m      (m),
    .nxt    (step_nxt)
  );

  // Operand magnitudes at issue time; unsigned ops pass through untouched.
  always_comb begin
    abs_a = operandA;
    abs_b = operandB;
    if (is_signed_op(op)) begin
      abs_a = operandA[WIDTH-1] ? (~operandA + {{(WIDTH-1){1'b0}}, 1'b1}) : operandA;
      abs_b = operandB[WIDTH-1] ? (~operandB + {{(WIDTH-1){1'b0}}, 1'b1}) : operandB;
    end else begin
      abs_a = operandA;
      abs_b = operandB;
    end
  end

  // Sign fix-up of the final {acc, q}; the most negative dividend / -1 wraps naturally.
  always_comb begin
    hi_n   = acc_q[2*WIDTH-1:WIDTH];
    lo_n   = acc_q[WIDTH-1:0];
    prod_n = acc_q;
    if (is_div) begin
      if (dbz) begin
        hi_n = a_raw;
        lo_n = {WIDTH{1'b1}};
      end else begin
        lo_n = neg_main ? (~acc_q[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1})
                        : acc_q[WIDTH-1:0];
        hi_n = neg_rem ? (~acc_q[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, 1'b1})
                       : acc_q[2*WIDTH-1:WIDTH];
      end
    end else begin
      prod_n = neg_main ? (~acc_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_q;
      hi_n   = prod_n[2*WIDTH-1:WIDTH];
      lo_n   = prod_n[WIDTH-1:0];
    end
  end

  // Control FSM, iteration counter and all architectural registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= {CW{1'b0}};
      is_div    <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      dbz       <= 1'b0;
      a_raw     <= {WIDTH{1'b0}};
      m         <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else begin
      done      <= 1'b0;
      divByZero <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= {CW{1'b0}};
            is_div   <= is_div_op(op);
            neg_main <= is_signed_op(op) & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
            neg_rem  <= is_signed_op(op) & operandA[WIDTH-1];
            dbz      <= is_div_op(op) & (operandB == {WIDTH{1'b0}});
            a_raw    <= operandA;
            m        <= abs_b;
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= step_nxt;
          count <= count + {{(CW-1){1'b0}}, 1'b1};
          if (count == CW'(ITER - 1)) begin
            state <= FIX;
          end else begin
            state <= RUN;
          end
        end
        FIX: begin
          hi        <= hi_n;
          lo        <= lo_n;
          done      <= 1'b1;
          divByZero <= dbz;
          busy      <= 1'b0;
          state     <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected HI/LO/divByZero
// and done cycle, a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_dbz;
    int          e_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  mult_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (divByZero === 1'b1 && done !== 1'b1) begin
      errors++;
      $display("FAIL dbz_outside_done: divByZero=1 without done (cycle %0d)", cycle);
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("hi", hi, e.e_hi);
        check("lo", lo, e.e_lo);
        check("divByZero", {31'd0, divByZero}, {31'd0, e.e_dbz});
        check("done_cycle", cycle, e.e_cyc);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    @(posedge clk); #1;
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(posedge clk); #1;
    sb.push_back('{eh, el, ed, cycle + 33});
    start = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    op = 2'($urandom_range(3, 0));
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb.size(), maxc);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; operandA = 32'd0; operandB = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    check("busy_run", {31'd0, busy}, 32'd1);
    wait_drain(60);
    issue(2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_drain(60);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    wait_drain(60);
    issue(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0);
    wait_drain(60);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_drain(60);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    wait_drain(60);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_drain(60);
    issue(2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_drain(60);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_drain(60);
    issue(2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    wait_drain(60);

    // Starts while busy must be ignored; old HI/LO stay visible mid-run.
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      start = (c == 2 || c == 9 || c == 19);
      op = 2'b01; operandA = 32'hFFFF_FFFF; operandB = 32'hFFFF_FFFF;
      if (c == 10) begin
        check("hold_hi", hi, 32'd5);
        check("hold_lo", lo, 32'hFFFF_FFFF);
        check("busy_mid", {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    wait_drain(60);

    // Start held high through DONE launches the next op 34 cycles later.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; operandA = 32'd100; operandB = 32'd7;
    @(posedge clk); #1;
    sb.push_back('{32'd2, 32'd14, 1'b0, cycle + 33});
    op = 2'b00; operandA = 32'hFFFF_FFF9; operandB = 32'd3;
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 60) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk); #1;
    sb.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, cycle + 33});
    start = 1'b0;
    wait_drain(80);

    // Reset in the middle of a run discards the operation entirely.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; operandA = 32'd9; operandB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);

    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    wait_drain(60);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
